// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/accumulator controller:
// FSM state encodings and the default datapath width.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAC_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder; the single arithmetic slice reused by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/accumulator controller: adds two WIDTH-bit operands LSB-first
// over WIDTH cycles through one full_adder, with optional accumulate feedback.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic             out_carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a         (sa_reg[0]),
        .b         (sb_reg[0]),
        .carry_in  (carry_reg),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            sa_reg        <= '0;
            sb_reg        <= '0;
            sr_reg        <= '0;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            out_carry_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (acc_clr) begin
                        acc_reg <= '0;
                    end
                    if (in_valid) begin
                        sa_reg    <= in_a;
                        // A same-cycle clear takes priority over the stored accumulator.
                        sb_reg    <= in_acc ? (acc_clr ? '0 : acc_reg) : in_b;
                        carry_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa_reg    <= sa_reg >> 1;
                    sb_reg    <= sb_reg >> 1;
                    sr_reg    <= {fa_sum, sr_reg[WIDTH-1:1]};
                    carry_reg <= fa_cout;
                    if (cnt_reg == LAST_BIT) begin
                        acc_reg       <= {fa_sum, sr_reg[WIDTH-1:1]};
                        out_carry_reg <= fa_cout;
                        state_reg     <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_RUN);
    assign out_valid = (state_reg == ST_DONE);
    assign out_sum   = sr_reg;
    assign out_carry = out_carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed scenarios plus a
// randomized regression against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_acc;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] acc_model = '0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_out_sum"},   {24'd0, out_sum},   32'd0);
        check({tag, "_out_carry"}, {31'd0, out_carry}, 32'd0);
    endtask

    task automatic clear_acc();
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        acc_model = '0;
        $display("acc_clr");
    endtask

    // One transaction: accept, run, optional backpressure, release.
    // rst_mid asserts reset during RUN cycle 3 instead of completing.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc, input logic clr,
                          input int hold, input logic rst_mid);
        logic [W-1:0] bop;
        logic [W:0]   exp;
        int           n;
        bop = acc ? (clr ? '0 : acc_model) : b;
        exp = {1'b0, a} + {1'b0, bop};

        @(negedge clk);
        in_a = a; in_b = b; in_acc = acc; acc_clr = clr; in_valid = 1'b1;
        check("in_ready_pre", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b0; in_acc = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom);

        if (rst_mid) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check_idle_zero("rst_mid");
            rst_n = 1'b1;
            acc_model = '0;
            $display("op a=%02h b=%02h acc=%0b clr=%0b -> reset mid-run", a, b, acc, clr);
        end else begin
            n = 0;
            while (busy && n < 40) begin
                n++;
                @(negedge clk);
            end
            check("busy_cycles", n, 32'd8);
            check("out_valid",   {31'd0, out_valid}, 32'd1);
            check("out_sum",     {24'd0, out_sum},   {24'd0, exp[W-1:0]});
            check("out_carry",   {31'd0, out_carry}, {31'd0, exp[W]});
            check("in_ready_done", {31'd0, in_ready}, 32'd0);
            acc_model = exp[W-1:0];

            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom);
                acc_clr  = 1'($urandom);
                in_a     = W'($urandom);
                @(negedge clk);
                in_valid = 1'b0; acc_clr = 1'b0;
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_sum",   {24'd0, out_sum},   {24'd0, exp[W-1:0]});
                check("hold_carry", {31'd0, out_carry}, {31'd0, exp[W]});
                check("hold_ready", {31'd0, in_ready},  32'd0);
            end

            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("rel_valid", {31'd0, out_valid}, 32'd0);
            check("rel_ready", {31'd0, in_ready},  32'd1);
            check("rel_busy",  {31'd0, busy},      32'd0);
            $display("op a=%02h b=%02h acc=%0b clr=%0b hold=%0d -> sum=%02h carry=%0b exp=%03h",
                     a, b, acc, clr, hold, out_sum, out_carry, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        // Basic add and overflow boundaries
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 1'b0);

        // Accumulate chain, then clear coinciding with an accumulate accept
        clear_acc();
        run_op(8'h10, 8'hEE, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'h20, 8'hEE, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'h07, 8'hEE, 1'b1, 1'b1, 0, 1'b0);

        // Backpressure with ignored in_valid / acc_clr pulses, then accumulate on top
        run_op(8'h3C, 8'h41, 1'b0, 1'b0, 5, 1'b0);
        run_op(8'h01, 8'h00, 1'b1, 1'b0, 0, 1'b0);

        // Reset mid-RUN; accumulator must come back zeroed
        run_op(8'hAA, 8'h55, 1'b0, 1'b0, 0, 1'b1);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);
        clear_acc();
        run_op(8'h05, 8'h99, 1'b1, 1'b0, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 15) == 0) clear_acc();
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
